line_buffer_ctrl: RTL

LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

---
 rtl/line_buffer_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/line_buffer_ctrl.sv
// Line buffer controller: raster pixels are written into SRAM_SIZE line memories and a full column is presented per pixel.
// Define LINE_BUF_FLUSH_EN to append 8 zero rows after the last input row of a frame.
//   state | meaning
//   IDLE  | waiting for sof_i, non-sof pixels dropped
//   FILL  | storing rows 0..SRAM_SIZE-2, no window output
//   RUN   | window complete, valid_o per accepted pixel
//   FLUSH | inserting zero rows, input stalled (LINE_BUF_FLUSH_EN only)
module line_buffer_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 12,
    parameter int SRAM_SIZE  = 18,
    parameter int IMG_WIDTH  = 4000,
    parameter int IMG_HEIGHT = 3000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           pix_i,
    input  logic                            valid_i,
    input  logic                            sof_i,
    output logic                            ready_o,
    output logic [SRAM_SIZE*DATA_WIDTH-1:0] data_o,
    output logic [4:0]                      head_num_o,
    output logic                            valid_o,
    output logic                            eof_o
);

    localparam int LW = $clog2(SRAM_SIZE);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] COL_LAST      = ADDR_WIDTH'(IMG_WIDTH - 1);
    localparam logic [RW-1:0]         ROW_LAST      = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0]         ROW_FILL_LAST = RW'(SRAM_SIZE - 2);
    localparam logic [LW-1:0]         LINE_LAST     = LW'(SRAM_SIZE - 1);

`ifdef LINE_BUF_FLUSH_EN
    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
`else
    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
`endif

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic [LW-1:0]           line_q, line_d;
    logic                    col_wrap;
    logic                    valid_q;
    logic                    eof_q;
    logic [DATA_WIDTH-1:0]   data_q [SRAM_SIZE];
    logic [DATA_WIDTH-1:0]   mem [SRAM_SIZE][2**ADDR_WIDTH];

    logic                    accept;
    logic                    restart;
    logic                    flush_wr;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_col;
    logic [LW-1:0]           wr_line;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [LW-1:0]           head;

`ifdef LINE_BUF_FLUSH_EN
    logic [2:0]              flush_row_q;
    assign ready_o  = (state_q != FLUSH);
    assign flush_wr = (state_q == FLUSH);
`else
    assign ready_o  = 1'b1;
    assign flush_wr = 1'b0;
`endif

    assign accept  = valid_i && ready_o;
    assign restart = accept && sof_i;
    assign wr_en   = (accept && (sof_i || (state_q != IDLE))) || flush_wr;
    // a restarting pixel lands at row 0 col 0 regardless of where the old frame was
    assign wr_col  = restart ? '0 : col_q;
    assign wr_line = restart ? '0 : line_q;
    assign wr_data = flush_wr ? '0 : pix_i;

    always_comb begin
        col_wrap = (col_q == COL_LAST);
        col_d    = col_wrap ? '0 : col_q + 1'b1;
        row_d    = col_wrap ? row_q + 1'b1 : row_q;
        line_d   = line_q;
        if (col_wrap) begin
            line_d = (line_q == LINE_LAST) ? '0 : line_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_line][wr_col] <= wr_data;
        end
    end

    // read-before-write: the slot being written is taken from the bypass path
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SRAM_SIZE; k++) begin
                data_q[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < SRAM_SIZE; k++) begin
                data_q[k] <= (wr_line == LW'(k)) ? wr_data : mem[k][wr_col];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            line_q  <= '0;
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
`ifdef LINE_BUF_FLUSH_EN
            flush_row_q <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
            if (restart) begin
                state_q <= FILL;
                col_q   <= ADDR_WIDTH'(1);
                row_q   <= '0;
                line_q  <= '0;
            end else begin
                case (state_q)
                    FILL: begin
                        if (accept) begin
                            col_q  <= col_d;
                            row_q  <= row_d;
                            line_q <= line_d;
                            if (col_wrap && (row_q == ROW_FILL_LAST)) begin
                                state_q <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (accept) begin
                            valid_q <= 1'b1;
                            if (col_wrap && (row_q == ROW_LAST)) begin
`ifdef LINE_BUF_FLUSH_EN
                                state_q     <= FLUSH;
                                col_q       <= col_d;
                                line_q      <= line_d;
                                flush_row_q <= '0;
`else
                                eof_q   <= 1'b1;
                                state_q <= IDLE;
                                col_q   <= '0;
                                row_q   <= '0;
                                line_q  <= '0;
`endif
                            end else begin
                                col_q  <= col_d;
                                row_q  <= row_d;
                                line_q <= line_d;
                            end
                        end
                    end
`ifdef LINE_BUF_FLUSH_EN
                    FLUSH: begin
                        valid_q <= 1'b1;
                        col_q   <= col_d;
                        line_q  <= line_d;
                        if (col_wrap) begin
                            flush_row_q <= flush_row_q + 1'b1;
                            if (flush_row_q == 3'd7) begin
                                eof_q   <= 1'b1;
                                state_q <= IDLE;
                                col_q   <= '0;
                                row_q   <= '0;
                                line_q  <= '0;
                            end
                        end
                    end
`endif
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign head       = (line_q == LINE_LAST) ? '0 : line_q + 1'b1;
    assign head_num_o = 5'(head);
    assign valid_o    = valid_q;
    assign eof_o      = eof_q;

    for (genvar k = 0; k < SRAM_SIZE; k++) begin : g_slot
        assign data_o[k*DATA_WIDTH +: DATA_WIDTH] = data_q[k];
    end

endmodule
